// File: rtl/cpu_trace_monitor_if.sv
// Signal bundle between the CPU-side probe points / trace reader and cpu_trace_monitor.
// The monitor uses the slave modport; whoever drives the probes and reads the trace uses master.
interface cpu_trace_monitor_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CYCLE_W = 32
);
  logic [PC_W-1:0]                     pc;
  logic [INSTR_W-1:0]                  instr;
  logic                                pc_stop;
  logic                                halt;
  logic                                op_err;
  logic                                fn_err;
  logic                                arm;
  logic                                rd_ready;
  logic                                rd_valid;
  logic [CYCLE_W+1+PC_W+INSTR_W-1:0]   rd_data;
  logic [CYCLE_W-1:0]                  cycle_count;
  logic [1:0]                          state;
  logic [1:0]                          trig_cause;
  logic [$clog2(DEPTH):0]              count;

  modport slave (
    input  pc, instr, pc_stop, halt, op_err, fn_err, arm, rd_ready,
    output rd_valid, rd_data, cycle_count, state, trig_cause, count
  );

  modport master (
    output pc, instr, pc_stop, halt, op_err, fn_err, arm, rd_ready,
    input  rd_valid, rd_data, cycle_count, state, trig_cause, count
  );
endinterface

// File: rtl/cpu_trace_monitor.sv
// Passive IF-stage trace monitor: circular capture buffer with cycle stamps, frozen a fixed
// number of entries after a HALT / unknown-opcode / unknown-function event, then drained.
module cpu_trace_monitor #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CYCLE_W   = 32,
  parameter int unsigned POST_TRIG = 4
) (
  input logic                  i_clock,
  input logic                  i_reset,
  cpu_trace_monitor_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = CYCLE_W + 1 + PC_W + INSTR_W;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StArmed  = 2'b01,
    StPost   = 2'b10,
    StFrozen = 2'b11
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [CYCLE_W-1:0]  r_cycle;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic [AW-1:0]       r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]       w_rd_ptr;
  logic [CW-1:0]       r_post_cnt, w_post_cnt_nxt;
  logic [1:0]          r_cause, w_cause_nxt;
  logic                w_capture;
  logic                w_trig;
  logic                w_rd_valid;
  logic                w_pop;
  logic [EW-1:0]       r_mem [DEPTH];

  assign w_trig     = bus.halt | bus.op_err | bus.fn_err;
  // Oldest entry sits count slots behind the write pointer; a full buffer gives rd_ptr == wr_ptr.
  assign w_rd_ptr   = r_wr_ptr - r_count[AW-1:0];
  assign w_rd_valid = (r_state == StFrozen) && (r_count != '0);
  assign w_pop      = w_rd_valid & bus.rd_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_post_cnt_nxt = r_post_cnt;
    w_cause_nxt    = r_cause;
    w_capture      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.arm) begin
          w_state_nxt  = StArmed;
          w_count_nxt  = '0;
          w_wr_ptr_nxt = '0;
          w_cause_nxt  = 2'b00;
        end
      end
      StArmed: begin
        w_capture = 1'b1;
        if (w_trig) begin
          if (bus.fn_err)      w_cause_nxt = 2'b11;
          else if (bus.op_err) w_cause_nxt = 2'b10;
          else                 w_cause_nxt = 2'b01;
          w_post_cnt_nxt = '0;
          w_state_nxt    = (POST_TRIG == 0) ? StFrozen : StPost;
        end
      end
      StPost: begin
        w_capture      = 1'b1;
        w_post_cnt_nxt = r_post_cnt + 1'b1;
        if (32'(w_post_cnt_nxt) == POST_TRIG) w_state_nxt = StFrozen;
      end
      StFrozen: begin
        if (bus.arm) begin
          w_state_nxt  = StArmed;
          w_count_nxt  = '0;
          w_wr_ptr_nxt = '0;
          w_cause_nxt  = 2'b00;
        end else if (w_pop) begin
          w_count_nxt = r_count - 1'b1;
        end
      end
    endcase

    if (w_capture) begin
      w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      if (r_count != Full) w_count_nxt = r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_cycle    <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_cause    <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_post_cnt <= w_post_cnt_nxt;
      r_cause    <= w_cause_nxt;
      if (r_cycle != '1) r_cycle <= r_cycle + 1'b1;
    end
  end

  // Buffer storage carries no reset; stale contents are never presented because count gates reads.
  always_ff @(posedge i_clock) begin
    if (i_reset && w_capture) begin
      r_mem[r_wr_ptr] <= {r_cycle, bus.pc_stop, bus.pc, bus.instr};
    end
  end

  assign bus.rd_valid    = w_rd_valid;
  assign bus.rd_data     = r_mem[w_rd_ptr];
  assign bus.cycle_count = r_cycle;
  assign bus.state       = r_state;
  assign bus.trig_cause  = r_cause;
  assign bus.count       = r_count;

endmodule
